// File: rtl/mmc1_sxrom_mapper.sv
// mmc1_sxrom_mapper: MMC1 mapper for the SNROM/SOROM/SUROM/SXROM board family.
// Rev 1.0
`default_nettype none

module mmc1_sxrom_mapper #(
  parameter int unsigned PRG_AW    = 22,
  parameter int unsigned CHR_AW    = 22,
  parameter int unsigned CHR_BASE  = 32'h0020_0000,
  parameter int unsigned WRAM_BASE = 32'h003C_0000,
  parameter bit          MMC1A     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [1:0]        board,
  input  logic              hard_mirror,
  input  logic              chr_ram,
  input  logic [15:0]       prg_ain,
  input  logic              prg_write,
  input  logic [7:0]        prg_din,
  input  logic [13:0]       chr_ain,
  output logic [PRG_AW-1:0] prg_aout,
  output logic              prg_allow,
  output logic [CHR_AW-1:0] chr_aout,
  output logic              chr_allow,
  output logic              vram_a10,
  output logic              vram_ce,
  output logic [2:0]        shift_cnt
);

  localparam logic [1:0] BOARD_SNROM = 2'd0;
  localparam logic [1:0] BOARD_SOROM = 2'd1;
  localparam logic [1:0] BOARD_SXROM = 2'd3;

  logic [4:0] control;
  logic [4:0] chr0;
  logic [4:0] chr1;
  logic [4:0] prg_bank;
  logic [3:0] sreg;
  logic [2:0] cnt;
  logic       blk;

  // Serial load port. blk filters the second cycle of back-to-back writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      control  <= 5'b01100;
      chr0     <= 5'd0;
      chr1     <= 5'd0;
      prg_bank <= 5'd0;
      sreg     <= 4'd0;
      cnt      <= 3'd0;
      blk      <= 1'b0;
    end else if (ce) begin
      if (!prg_write) begin
        blk <= 1'b0;
      end else if (prg_ain[15] && !blk) begin
        blk <= 1'b1;
        if (prg_din[7]) begin
          cnt     <= 3'd0;
          sreg    <= 4'd0;
          control <= control | 5'b01100;
        end else if (cnt == 3'd4) begin
          case (prg_ain[14:13])
            2'd0:    control  <= {prg_din[0], sreg};
            2'd1:    chr0     <= {prg_din[0], sreg};
            2'd2:    chr1     <= {prg_din[0], sreg};
            default: prg_bank <= {prg_din[0], sreg};
          endcase
          cnt  <= 3'd0;
          sreg <= 4'd0;
        end else begin
          sreg <= {prg_din[0], sreg[3:1]};
          cnt  <= cnt + 3'd1;
        end
      end
    end
  end

  assign shift_cnt = cnt;

  logic [3:0] prg_page;
  always_comb begin
    prg_page = 4'h0;
    case (control[3:2])
      2'b10:   prg_page = prg_ain[14] ? prg_bank[3:0] : 4'h0;
      2'b11:   prg_page = prg_ain[14] ? 4'hF : prg_bank[3:0];
      default: prg_page = {prg_bank[3:1], prg_ain[14]};
    endcase
  end

  // SUROM and SXROM (boards 2 and 3) both use chr0[4] as the 256 KB outer bank.
  logic outer_bank;
  assign outer_bank = board[1] ? chr0[4] : 1'b0;

  logic [1:0] ram_bank;
  always_comb begin
    ram_bank = 2'b00;
    case (board)
      BOARD_SOROM: ram_bank = {1'b0, chr0[3]};
      BOARD_SXROM: ram_bank = chr0[3:2];
      default:     ram_bank = 2'b00;
    endcase
  end

  logic ram_en;
  logic wram_sel;
  assign ram_en   = ((MMC1A != 1'b0) || !prg_bank[4]) && !(board == BOARD_SNROM && chr0[4]);
  assign wram_sel = (prg_ain[15:13] == 3'b011);

  logic [18:0] rom_addr;
  logic [14:0] ram_off;
  assign rom_addr = {outer_bank, prg_page, prg_ain[13:0]};
  assign ram_off  = {ram_bank, prg_ain[12:0]};

  assign prg_aout  = wram_sel ? (PRG_AW'(WRAM_BASE) | PRG_AW'(ram_off)) : PRG_AW'(rom_addr);
  assign prg_allow = (prg_ain[15] && !prg_write) || (wram_sel && ram_en);

  logic [4:0] chr_page;
  assign chr_page = control[4] ? (chr_ain[12] ? chr1 : chr0) : {chr0[4:1], chr_ain[12]};
  assign chr_aout = CHR_AW'(CHR_BASE) | CHR_AW'({chr_page, chr_ain[11:0]});
  assign chr_allow = chr_ram;
  assign vram_ce   = chr_ain[13];

  logic [1:0] mirror;
  assign mirror = hard_mirror ? 2'b10 : control[1:0];

  always_comb begin
    vram_a10 = 1'b0;
    case (mirror)
      2'b00:   vram_a10 = 1'b0;
      2'b01:   vram_a10 = 1'b1;
      2'b10:   vram_a10 = chr_ain[10];
      default: vram_a10 = chr_ain[11];
    endcase
  end

  logic unused_din;
  assign unused_din = ^prg_din[6:1];

endmodule

`default_nettype wire

// File: tb/tb_mmc1_sxrom_mapper.sv
// Directed bench for mmc1_sxrom_mapper: vector table plus serial-load sequences.
`default_nettype none

module tb_mmc1_sxrom_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [1:0]  board;
  logic        hard_mirror;
  logic        chr_ram;
  logic [15:0] prg_ain;
  logic        prg_write;
  logic [7:0]  prg_din;
  logic [13:0] chr_ain;

  logic [21:0] prg_aout,  prg_aout_a;
  logic        prg_allow, prg_allow_a;
  logic [21:0] chr_aout,  chr_aout_a;
  logic        chr_allow, chr_allow_a;
  logic        vram_a10,  vram_a10_a;
  logic        vram_ce,   vram_ce_a;
  logic [2:0]  shift_cnt, shift_cnt_a;

  always #5 clk = ~clk;

  mmc1_sxrom_mapper #(.MMC1A(1'b0)) dut (
    .clk(clk), .reset(reset), .ce(ce), .board(board), .hard_mirror(hard_mirror),
    .chr_ram(chr_ram), .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
    .chr_ain(chr_ain), .prg_aout(prg_aout), .prg_allow(prg_allow), .chr_aout(chr_aout),
    .chr_allow(chr_allow), .vram_a10(vram_a10), .vram_ce(vram_ce), .shift_cnt(shift_cnt)
  );

  mmc1_sxrom_mapper #(.MMC1A(1'b1)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .board(board), .hard_mirror(hard_mirror),
    .chr_ram(chr_ram), .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
    .chr_ain(chr_ain), .prg_aout(prg_aout_a), .prg_allow(prg_allow_a), .chr_aout(chr_aout_a),
    .chr_allow(chr_allow_a), .vram_a10(vram_a10_a), .vram_ce(vram_ce_a), .shift_cnt(shift_cnt_a)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // One accepted-edge CPU write; ce drops again afterwards.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    ce = 1'b1; prg_write = 1'b1; prg_ain = a; prg_din = d;
    @(negedge clk);
    ce = 1'b0; prg_write = 1'b0;
  endtask

  task automatic idle();
    ce = 1'b1; prg_write = 1'b0;
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic load_reg(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      wr(a, {7'd0, v[i]});
      idle();
    end
  endtask

  task automatic rd(input logic [15:0] a);
    prg_ain = a; prg_write = 1'b0; ce = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [1:0]  board;
    logic        hm;
    logic [15:0] ain;
    logic        wr;
    logic [13:0] cain;
    logic        chk_aout;
    logic [21:0] aout;
    logic        allow;
    logic [21:0] caout;
    logic        a10;
    logic        vce;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // State when applied: control=5'b01110, chr0=5'h10, chr1=0, prg_bank=5.
    vecs[0] = '{2'd2, 1'b0, 16'hC000, 1'b0, 14'h0000, 1'b1, 22'h07C000, 1'b1, 22'h210000, 1'b0, 1'b0};
    vecs[1] = '{2'd3, 1'b0, 16'hC000, 1'b0, 14'h1ABC, 1'b1, 22'h07C000, 1'b1, 22'h211ABC, 1'b0, 1'b0};
    vecs[2] = '{2'd1, 1'b0, 16'hC000, 1'b0, 14'h0400, 1'b1, 22'h03C000, 1'b1, 22'h210400, 1'b1, 1'b0};
    vecs[3] = '{2'd0, 1'b0, 16'h6000, 1'b0, 14'h2400, 1'b1, 22'h3C0000, 1'b0, 22'h210400, 1'b1, 1'b1};
    vecs[4] = '{2'd1, 1'b0, 16'h7FFF, 1'b0, 14'h0000, 1'b1, 22'h3C1FFF, 1'b1, 22'h210000, 1'b0, 1'b0};
    vecs[5] = '{2'd0, 1'b0, 16'h8000, 1'b1, 14'h0800, 1'b1, 22'h014000, 1'b0, 22'h210800, 1'b0, 1'b0};
    vecs[6] = '{2'd0, 1'b0, 16'h4000, 1'b0, 14'h3FFF, 1'b0, 22'h000000, 1'b0, 22'h211FFF, 1'b1, 1'b1};
    vecs[7] = '{2'd2, 1'b0, 16'h6000, 1'b1, 14'h0000, 1'b1, 22'h3C0000, 1'b1, 22'h210000, 1'b0, 1'b0};
    vecs[8] = '{2'd2, 1'b0, 16'hA000, 1'b0, 14'h0000, 1'b1, 22'h056000, 1'b1, 22'h210000, 1'b0, 1'b0};

    reset = 1'b1; ce = 1'b0; board = 2'd0; hard_mirror = 1'b0; chr_ram = 1'b1;
    prg_ain = 16'h0000; prg_write = 1'b0; prg_din = 8'h00; chr_ain = 14'h0000;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    rd(16'hC000);
    check("reset_c000", prg_aout, 32'h03C000);
    check("reset_c000_allow", prg_allow, 1);
    rd(16'h8000);
    check("reset_8000", prg_aout, 32'h000000);
    check("reset_shift_cnt", shift_cnt, 0);

    load_reg(16'hE000, 5'd5);
    check("prg_load_cnt", shift_cnt, 0);
    rd(16'h8000);
    check("prg_bank5_8000", prg_aout, 32'h014000);

    wr(16'h8000, 8'h01);
    wr(16'h8000, 8'h01);
    check("back_to_back_cnt", shift_cnt, 1);
    idle();
    wr(16'h8000, 8'h01);
    check("after_idle_cnt", shift_cnt, 2);
    idle();
    wr(16'h8000, 8'h80);
    idle();
    check("bit7_clear_cnt", shift_cnt, 0);

    load_reg(16'h8000, 5'b00010);
    rd(16'hC000);
    check("pp00_c000", prg_aout, 32'h014000);
    for (int i = 0; i < 3; i++) begin
      wr(16'h8000, 8'h01);
      idle();
    end
    check("three_bits_cnt", shift_cnt, 3);
    wr(16'h8000, 8'h80);
    idle();
    check("bit7_after3_cnt", shift_cnt, 0);
    rd(16'hC000);
    check("bit7_pp11_c000", prg_aout, 32'h03C000);
    chr_ain = 14'h0400; #1;
    check("mm10_kept", vram_a10, 1);

    load_reg(16'hA000, 5'h10);

    for (int i = 0; i < 9; i++) begin
      board = vecs[i].board; hard_mirror = vecs[i].hm; prg_ain = vecs[i].ain;
      prg_write = vecs[i].wr; chr_ain = vecs[i].cain; ce = 1'b0;
      #1;
      if (vecs[i].chk_aout) check($sformatf("vec%0d_prg_aout", i), prg_aout, vecs[i].aout);
      check($sformatf("vec%0d_prg_allow", i), prg_allow, vecs[i].allow);
      check($sformatf("vec%0d_chr_aout", i), chr_aout, vecs[i].caout);
      check($sformatf("vec%0d_vram_a10", i), vram_a10, vecs[i].a10);
      check($sformatf("vec%0d_vram_ce", i), vram_ce, vecs[i].vce);
    end
    prg_write = 1'b0; board = 2'd0;

    chr_ram = 1'b0; #1;
    check("chr_allow_0", chr_allow, 0);
    chr_ram = 1'b1; #1;
    check("chr_allow_1", chr_allow, 1);

    wr(16'h8000, 8'h00);
    idle();
    wr(16'h6000, 8'h01);
    check("low_write_ignored", shift_cnt, 1);
    ce = 1'b0; prg_write = 1'b1; prg_ain = 16'h8000; prg_din = 8'h01;
    @(negedge clk);
    prg_write = 1'b0;
    check("ce0_write_ignored", shift_cnt, 1);
    idle();
    wr(16'h8000, 8'h80);
    idle();

    load_reg(16'hA000, 5'h0C);
    board = 2'd3;
    rd(16'h6000);
    check("sxrom_ram_addr", prg_aout, 32'h3C6000);
    check("sxrom_ram_allow", prg_allow, 1);
    load_reg(16'hE000, 5'h10);
    rd(16'h6000);
    check("ram_disable", prg_allow, 0);
    check("mmc1a_ram_allow", prg_allow_a, 1);

    load_reg(16'h8000, 5'h0F);
    rd(16'h8000);
    chr_ain = 14'h0800; #1;
    check("mm11_a11_hi", vram_a10, 1);
    chr_ain = 14'h0400; #1;
    check("mm11_a11_lo", vram_a10, 0);
    hard_mirror = 1'b1; #1;
    check("hard_mirror", vram_a10, 1);
    hard_mirror = 1'b0;

    load_reg(16'h8000, 5'h1F);
    load_reg(16'hC000, 5'h07);
    chr_ain = 14'h1000; #1;
    check("c1_chr1", chr_aout, 32'h207000);
    chr_ain = 14'h0000; #1;
    check("c1_chr0", chr_aout, 32'h20C000);

    board = 2'd0;
    for (int i = 0; i < 4; i++) begin
      wr(16'hA000, 8'h01);
      idle();
    end
    check("four_bits_cnt", shift_cnt, 4);
    reset = 1'b1;
    wr(16'hA000, 8'h01);
    reset = 1'b0;
    check("reset_5th_cnt", shift_cnt, 0);
    chr_ain = 14'h1000; #1;
    check("reset_5th_chr0", chr_aout, 32'h201000);
    rd(16'hC000);
    check("reset_5th_c000", prg_aout, 32'h03C000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
